// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
//
// Sequences one ADC capture in the adc_sampleclk domain:
//   arm edge -> presample FILL -> WAIT_TRIG -> OFFSET delay -> CAPTURE window,
//   repeated for multi-segment captures (timed GAP or re-trigger via FILL).
//
// Ports:
//   adc_sampleclk            sole clock, rising edge
//   reset_n                  asynchronous active-low reset
//   arm                      synchronized arm level (rise starts, low aborts)
//   trigger                  single-cycle qualified trigger pulse
//   presamples               samples collected before a trigger is accepted
//   samples                  total samples per segment incl. presamples
//   offset                   cycles between trigger and capture start
//   num_segments             segments per arm (0 behaves as 1)
//   segment_cycles           spacing of segment starts in timed mode
//   segment_cycle_counter_en 1 = timed segments, 0 = trigger per segment
//   fifo_overflow            FIFO overflow flag
//   capture_en               FIFO write-enable window
//   seg_start                pulse on the first capture_en cycle of a segment
//   armed                    high in FILL and WAIT_TRIG
//   capture_done             high in DONE
//   overflow_err             sticky overflow flag, cleared on the next arm edge
//   seg_count                completed segments
//   state_o                  encoded state
// -----------------------------------------------------------------------------
module capture_sequencer #(
  parameter int pSEG_CNT_W = 16,
  parameter int pSEG_CYC_W = 20,
  parameter int pPRE_W     = 15
) (
  input  logic                  adc_sampleclk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [pPRE_W-1:0]     presamples,
  input  logic [31:0]           samples,
  input  logic [31:0]           offset,
  input  logic [pSEG_CNT_W-1:0] num_segments,
  input  logic [pSEG_CYC_W-1:0] segment_cycles,
  input  logic                  segment_cycle_counter_en,
  input  logic                  fifo_overflow,
  output logic                  capture_en,
  output logic                  seg_start,
  output logic                  armed,
  output logic                  capture_done,
  output logic                  overflow_err,
  output logic [pSEG_CNT_W-1:0] seg_count,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_OFFSET    = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Post-trigger length: samples - presamples, never below one sample.
  function automatic logic [31:0] sat_post(input logic [31:0] smp,
                                           input logic [31:0] pre);
    logic signed [32:0] diff;
    diff = $signed({1'b0, smp}) - $signed({1'b0, pre});
    if (diff < 33'sd1) sat_post = 32'd1;
    else               sat_post = diff[31:0];
  endfunction

  // Gap counter value at which the next segment is launched. When the
  // requested spacing cannot fit the window plus one idle cycle, segments
  // run back-to-back with a single GAP cycle.
  function automatic logic [31:0] gap_target(input logic [31:0] seg_cyc,
                                             input logic [31:0] post);
    if (seg_cyc > post) gap_target = seg_cyc - 32'd1;
    else                gap_target = post;
  endfunction

  function automatic logic [pSEG_CNT_W-1:0] seg_floor(input logic [pSEG_CNT_W-1:0] n);
    if (n == '0) seg_floor = {{(pSEG_CNT_W-1){1'b0}}, 1'b1};
    else         seg_floor = n;
  endfunction

  state_t state, next_state;

  logic                  arm_q;
  logic [31:0]           cnt;
  logic [31:0]           gap_cnt;

  logic [31:0]           pre_s;
  logic [31:0]           post_s;
  logic [31:0]           offset_s;
  logic [31:0]           gap_tgt_s;
  logic [pSEG_CNT_W-1:0] nseg_s;
  logic                  timed_s;

  logic [31:0] pre_in;
  logic [31:0] post_in;
  logic [31:0] seg_cyc_in;
  logic        arm_rise, start, active, abort, ovf;
  logic        fill_last, off_last, cap_last, gap_hit, last_seg, seg_done;
  logic        seg_entry, next_cap_en, next_armed;

  assign pre_in     = {{(32-pPRE_W){1'b0}}, presamples};
  assign seg_cyc_in = {{(32-pSEG_CYC_W){1'b0}}, segment_cycles};
  assign post_in    = sat_post(samples, pre_in);

  assign arm_rise = arm & ~arm_q;
  assign start    = (state == ST_IDLE) & arm_rise;
  assign active   = (state == ST_FILL) | (state == ST_WAIT_TRIG) |
                    (state == ST_OFFSET) | (state == ST_CAPTURE) |
                    (state == ST_GAP);
  // DONE also leaves on arm low, so abort covers every non-IDLE state.
  assign abort    = (state != ST_IDLE) & ~arm;
  assign ovf      = active & arm & fifo_overflow;

  // cnt is zero on the first cycle of every state.
  assign fill_last = (pre_s == 32'd0) | (cnt == pre_s - 32'd1);
  assign off_last  = (cnt == offset_s - 32'd1);
  assign cap_last  = (cnt == post_s - 32'd1);
  assign gap_hit   = (gap_cnt == gap_tgt_s);
  assign last_seg  = (({1'b0, seg_count} + 1'b1) == {1'b0, nseg_s});
  assign seg_done  = (state == ST_CAPTURE) & cap_last & ~abort & ~ovf;

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else if (ovf) begin
      next_state = ST_DONE;
    end else begin
      case (state)
        ST_IDLE:      if (arm_rise) next_state = ST_FILL;
        ST_FILL:      if (fill_last) next_state = ST_WAIT_TRIG;
        ST_WAIT_TRIG: begin
          if (trigger) begin
            if (offset_s == 32'd0) next_state = ST_CAPTURE;
            else                   next_state = ST_OFFSET;
          end
        end
        ST_OFFSET:    if (off_last) next_state = ST_CAPTURE;
        ST_CAPTURE: begin
          if (cap_last) begin
            if (last_seg)     next_state = ST_DONE;
            else if (timed_s) next_state = ST_GAP;
            else              next_state = ST_FILL;
          end
        end
        ST_GAP:       if (gap_hit) next_state = ST_CAPTURE;
        ST_DONE:      next_state = ST_DONE;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  assign seg_entry   = (next_state == ST_CAPTURE) & (state != ST_CAPTURE);
  assign next_cap_en = (next_state == ST_FILL) | (next_state == ST_WAIT_TRIG) |
                       (next_state == ST_CAPTURE);
  assign next_armed  = (next_state == ST_FILL) | (next_state == ST_WAIT_TRIG);

  // State, counters and registered outputs (outputs decoded from next_state
  // so they line up with the state register)
  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      arm_q        <= 1'b0;
      cnt          <= '0;
      gap_cnt      <= '0;
      seg_count    <= '0;
      overflow_err <= 1'b0;
      capture_en   <= 1'b0;
      seg_start    <= 1'b0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      state <= next_state;
      arm_q <= arm;

      if ((next_state != state) || (next_state == ST_IDLE) || (next_state == ST_DONE))
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;

      // Gap counter spans the whole segment period, starting at CAPTURE entry.
      if (seg_entry)
        gap_cnt <= '0;
      else if ((state == ST_CAPTURE) || (state == ST_GAP))
        gap_cnt <= gap_cnt + 32'd1;

      if (start)         seg_count <= '0;
      else if (seg_done) seg_count <= seg_count + 1'b1;

      if (start)    overflow_err <= 1'b0;
      else if (ovf) overflow_err <= 1'b1;

      capture_en   <= next_cap_en;
      seg_start    <= seg_entry;
      armed        <= next_armed;
      capture_done <= (next_state == ST_DONE);
    end
  end

  // Settings shadow, frozen at the arm edge
  always_ff @(posedge adc_sampleclk) begin
    if (start) begin
      pre_s     <= pre_in;
      post_s    <= post_in;
      offset_s  <= offset;
      gap_tgt_s <= gap_target(seg_cyc_in, post_in);
      nseg_s    <= seg_floor(num_segments);
      timed_s   <= segment_cycle_counter_en;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
//
// Self-checking bench for capture_sequencer. Each scenario arms the sequencer,
// plays a per-cycle trigger schedule and compares every output cycle by cycle
// against a timeline computed from the capture rules (fill length, trigger
// search, offset, window length, segment spacing). Directed sequences cover
// abort, overflow, overflow clear on re-arm and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;

  localparam int NCYC = 160;

  logic        adc_sampleclk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic        trigger;
  logic [14:0] presamples;
  logic [31:0] samples;
  logic [31:0] offset;
  logic [15:0] num_segments;
  logic [19:0] segment_cycles;
  logic        segment_cycle_counter_en;
  logic        fifo_overflow;
  logic        capture_en;
  logic        seg_start;
  logic        armed;
  logic        capture_done;
  logic        overflow_err;
  logic [15:0] seg_count;
  logic [2:0]  state_o;

  capture_sequencer #(
    .pSEG_CNT_W(16),
    .pSEG_CYC_W(20),
    .pPRE_W    (15)
  ) dut (
    .adc_sampleclk            (adc_sampleclk),
    .reset_n                  (reset_n),
    .arm                      (arm),
    .trigger                  (trigger),
    .presamples               (presamples),
    .samples                  (samples),
    .offset                   (offset),
    .num_segments             (num_segments),
    .segment_cycles           (segment_cycles),
    .segment_cycle_counter_en (segment_cycle_counter_en),
    .fifo_overflow            (fifo_overflow),
    .capture_en               (capture_en),
    .seg_start                (seg_start),
    .armed                    (armed),
    .capture_done             (capture_done),
    .overflow_err             (overflow_err),
    .seg_count                (seg_count),
    .state_o                  (state_o)
  );

  always #5 adc_sampleclk = ~adc_sampleclk;

  int checks = 0;
  int errors = 0;

  // Scenario configuration and trigger schedule
  int c_pre, c_smp, c_off, c_nsg, c_scyc;
  bit c_timed;
  bit trig_q [NCYC];

  // Expected timeline: state per cycle, seg_start pulses, seg_count
  int e_st [NCYC];
  bit e_ss [NCYC];
  int e_sc [NCYC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_sampleclk);
    #1;
  endtask

  task automatic set_st(input int i, input int v);
    if (i >= 0 && i < NCYC) e_st[i] = v;
  endtask

  // Timeline from the rules, cycle 1 being the first cycle after the arm edge.
  task automatic build_model();
    int post, f, nseg, gsp, c, t, s, prev_s;
    bit found, stop;
    post = (c_smp > c_pre) ? c_smp - c_pre : 1;
    f    = (c_pre == 0) ? 1 : c_pre;
    nseg = (c_nsg == 0) ? 1 : c_nsg;
    gsp  = (c_scyc > post + 1) ? c_scyc : post + 1;
    for (int i = 0; i < NCYC; i++) begin
      e_st[i] = 0; e_ss[i] = 1'b0; e_sc[i] = 0;
    end
    c = 1; prev_s = 0; stop = 1'b0; s = 0;
    for (int k = 0; k < nseg && !stop; k++) begin
      if (k == 0 || !c_timed) begin
        for (int i = c; i < c + f; i++) set_st(i, 1);
        t = c + f; found = 1'b0;
        while (t < NCYC && !found) begin
          set_st(t, 2);
          if (trig_q[t]) found = 1'b1;
          else           t++;
        end
        if (!found) stop = 1'b1;
        else begin
          s = t + 1 + c_off;
          for (int i = t + 1; i < s; i++) set_st(i, 3);
        end
      end else begin
        s = prev_s + gsp;
        for (int i = c; i < s; i++) set_st(i, 5);
      end
      if (!stop) begin
        for (int i = s; i < s + post; i++) set_st(i, 4);
        if (s < NCYC) e_ss[s] = 1'b1;
        for (int i = s + post; i < NCYC; i++) e_sc[i] = k + 1;
        c = s + post; prev_s = s;
      end
    end
    if (!stop) for (int i = c; i < NCYC; i++) set_st(i, 6);
  endtask

  task automatic compare_cycle(input string name, input int k);
    int st;
    st = e_st[k];
    check($sformatf("%s@%0d state", name, k), 32'(state_o), st);
    check($sformatf("%s@%0d capture_en", name, k), 32'(capture_en),
          (st == 1 || st == 2 || st == 4) ? 1 : 0);
    check($sformatf("%s@%0d armed", name, k), 32'(armed), (st == 1 || st == 2) ? 1 : 0);
    check($sformatf("%s@%0d capture_done", name, k), 32'(capture_done), (st == 6) ? 1 : 0);
    check($sformatf("%s@%0d seg_start", name, k), 32'(seg_start), 32'(e_ss[k]));
    check($sformatf("%s@%0d seg_count", name, k), 32'(seg_count), e_sc[k]);
    check($sformatf("%s@%0d overflow_err", name, k), 32'(overflow_err), 0);
  endtask

  task automatic drive_cfg();
    presamples               = 15'(c_pre);
    samples                  = 32'(c_smp);
    offset                   = 32'(c_off);
    num_segments             = 16'(c_nsg);
    segment_cycles           = 20'(c_scyc);
    segment_cycle_counter_en = c_timed;
  endtask

  task automatic clear_trig();
    for (int i = 0; i < NCYC; i++) trig_q[i] = 1'b0;
  endtask

  task automatic set_cfg(input int pre, input int smp, input int off,
                         input int nsg, input int scyc, input bit timed);
    c_pre = pre; c_smp = smp; c_off = off; c_nsg = nsg; c_scyc = scyc; c_timed = timed;
  endtask

  task automatic run_scn(input string name);
    arm = 1'b0; trigger = 1'b0; fifo_overflow = 1'b0;
    repeat (2) tick();
    drive_cfg();
    build_model();
    arm = 1'b1;
    for (int k = 1; k < NCYC; k++) begin
      tick();
      trigger = trig_q[k];
      // Settings move after the arm edge; the captured shadow must not.
      if (k == 2) begin
        presamples     = 15'($urandom_range(0, 20));
        samples        = $urandom_range(0, 30);
        offset         = $urandom_range(0, 9);
        num_segments   = 16'($urandom_range(0, 5));
        segment_cycles = 20'($urandom_range(0, 30));
        segment_cycle_counter_en = ~c_timed;
      end
      @(negedge adc_sampleclk);
      compare_cycle(name, k);
    end
    arm = 1'b0; trigger = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " state"},        32'(state_o), 0);
    check({name, " capture_en"},   32'(capture_en), 0);
    check({name, " seg_start"},    32'(seg_start), 0);
    check({name, " armed"},        32'(armed), 0);
    check({name, " capture_done"}, 32'(capture_done), 0);
    check({name, " overflow_err"}, 32'(overflow_err), 0);
    check({name, " seg_count"},    32'(seg_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; arm = 1'b0; trigger = 1'b0; fifo_overflow = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    drive_cfg();
    repeat (2) tick();
    check_all_zero("reset");
    reset_n = 1'b1;

    // Presample fill, early triggers ignored, trigger on the last FILL cycle ignored
    set_cfg(4, 10, 0, 1, 0, 1'b0);
    clear_trig(); trig_q[2] = 1'b1; trig_q[4] = 1'b1; trig_q[10] = 1'b1;
    run_scn("fill_trig");

    // Offset delay
    set_cfg(0, 3, 5, 1, 0, 1'b0);
    clear_trig(); trig_q[3] = 1'b1; trig_q[5] = 1'b1;
    run_scn("offset5");

    // Timed segments, spaced 20 apart; later triggers ignored
    set_cfg(0, 8, 0, 3, 20, 1'b1);
    clear_trig(); trig_q[3] = 1'b1; trig_q[30] = 1'b1; trig_q[50] = 1'b1;
    run_scn("timed20");

    // Timed segments, spacing below window length -> one idle cycle between
    set_cfg(0, 8, 0, 3, 5, 1'b1);
    clear_trig(); trig_q[3] = 1'b1;
    run_scn("timed5");

    // Triggered segments, second trigger never comes
    set_cfg(2, 5, 0, 2, 0, 1'b0);
    clear_trig(); trig_q[6] = 1'b1;
    run_scn("retrig_wait");

    // samples below presamples -> single-sample window
    set_cfg(5, 2, 1, 2, 0, 1'b0);
    clear_trig(); trig_q[8] = 1'b1; trig_q[12] = 1'b1; trig_q[30] = 1'b1;
    run_scn("post_sat");

    for (int r = 0; r < 30; r++) begin
      set_cfg($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 6),
              $urandom_range(0, 3), $urandom_range(0, 25), 1'($urandom_range(0, 1)));
      clear_trig();
      for (int i = 1; i < NCYC; i++) trig_q[i] = ($urandom_range(0, 5) == 0);
      run_scn($sformatf("rnd%0d", r));
    end

    // Abort in the second timed segment: CAPTURE 4..7, GAP, CAPTURE 14..17
    arm = 1'b0; trigger = 1'b0;
    repeat (2) tick();
    set_cfg(0, 4, 0, 2, 10, 1'b1);
    drive_cfg();
    arm = 1'b1;                      // cycle 0
    repeat (3) tick();               // cycle 3
    trigger = 1'b1;
    tick();                          // cycle 4
    trigger = 1'b0;
    @(negedge adc_sampleclk);
    check("abort seg_start c4", 32'(seg_start), 1);
    repeat (11) tick();              // cycle 15
    arm = 1'b0;
    @(negedge adc_sampleclk);
    check("abort state c15", 32'(state_o), 4);
    check("abort capture_en c15", 32'(capture_en), 1);
    tick();                          // cycle 16
    @(negedge adc_sampleclk);
    check("abort state c16", 32'(state_o), 0);
    check("abort capture_en c16", 32'(capture_en), 0);
    check("abort seg_count held", 32'(seg_count), 1);

    // Overflow in WAIT_TRIG: FILL 1..2, WAIT 3..
    repeat (2) tick();
    set_cfg(2, 10, 0, 1, 0, 1'b0);
    drive_cfg();
    arm = 1'b1;                      // cycle 0
    repeat (4) tick();               // cycle 4
    @(negedge adc_sampleclk);
    check("ovf state c4", 32'(state_o), 2);
    fifo_overflow = 1'b1;
    tick();                          // cycle 5
    fifo_overflow = 1'b0;
    trigger = 1'b1;
    @(negedge adc_sampleclk);
    check("ovf state c5", 32'(state_o), 6);
    check("ovf capture_done c5", 32'(capture_done), 1);
    check("ovf overflow_err c5", 32'(overflow_err), 1);
    check("ovf capture_en c5", 32'(capture_en), 0);
    tick();                          // cycle 6
    trigger = 1'b0;
    arm = 1'b0;
    @(negedge adc_sampleclk);
    check("ovf hold done c6", 32'(state_o), 6);
    tick();                          // cycle 7
    arm = 1'b1;
    @(negedge adc_sampleclk);
    check("ovf idle state c7", 32'(state_o), 0);
    check("ovf sticky c7", 32'(overflow_err), 1);
    check("ovf done clear c7", 32'(capture_done), 0);
    tick();                          // cycle 8: FILL 8..9, WAIT 10..
    @(negedge adc_sampleclk);
    check("rearm state c8", 32'(state_o), 1);
    check("rearm overflow_err c8", 32'(overflow_err), 0);
    check("rearm capture_en c8", 32'(capture_en), 1);

    // Asynchronous reset in the middle of a capture window (CAPTURE 11..18)
    repeat (2) tick();               // cycle 10
    trigger = 1'b1;
    tick();                          // cycle 11
    trigger = 1'b0;
    repeat (2) tick();               // cycle 13
    @(negedge adc_sampleclk);
    check("rst pre state", 32'(state_o), 4);
    check("rst pre capture_en", 32'(capture_en), 1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    reset_n = 1'b1;
    arm = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
